stack_pingpong_ctrl: RTL and testbench

//  Sequences two spike stacks as a ping-pong pair between a spike producer and the next-layer consumer.
//  The write bank collects spike addresses for the current timestep. On step_end the banks swap.
//  The former write bank is then streamed (oldest first) to the consumer and cleared.

---
 rtl/stack_pingpong_ctrl_pkg.sv | 10 +
 rtl/stack_pingpong_ctrl_bank_mux.sv | 17 +
 rtl/stack_pingpong_ctrl.sv | 88 ++++++++
 tb/tb_stack_pingpong_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pingpong_ctrl_pkg.sv
// stack_pingpong_ctrl_pkg: read-side FSM states and the clogb2 helper shared with the spike stacks
package stack_pingpong_ctrl_pkg;
  typedef enum logic [1:0] {R_IDLE, R_START, R_STREAM, R_CLEAR} rd_state_t;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/stack_pingpong_ctrl_bank_mux.sv
// stack_pingpong_ctrl_bank_mux: selects dout/done/empty of the read-bank stack
module stack_pingpong_ctrl_bank_mux #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_dout0,
  input  logic [DATA_WIDTH-1:0] i_dout1,
  input  logic [1:0]            i_done,
  input  logic [1:0]            i_empty,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_done,
  output logic                  o_empty
);
  assign o_dout  = i_sel ? i_dout1 : i_dout0;
  assign o_done  = i_done[i_sel];
  assign o_empty = i_empty[i_sel];
endmodule

// File: rtl/stack_pingpong_ctrl.sv
// stack_pingpong_ctrl: ping-pong sequencing of two spike stacks between a producer and a consumer
module stack_pingpong_ctrl
  import stack_pingpong_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  step_end,
  input  logic                  cons_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  step_done,
  output logic [DATA_WIDTH-1:0] stk_din,
  output logic [1:0]            stk_wr_en,
  output logic [1:0]            stk_clear,
  output logic [1:0]            stk_stream_out,
  input  logic [DATA_WIDTH-1:0] stk_dout0,
  input  logic [DATA_WIDTH-1:0] stk_dout1,
  input  logic [1:0]            stk_done,
  input  logic [1:0]            stk_empty,
  output logic                  bank_sel,
  output logic                  overflow
);
  localparam int CW = clogb2(DEPTH);
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);
  rd_state_t r_state, w_state_nxt;
  logic r_bank_sel, r_swap_pend, r_overflow, r_empty_lat;
  logic [CW:0] r_wr_cnt;
  logic [DATA_WIDTH-1:0] w_dout;
  logic w_rd, w_done, w_empty, w_wr, w_swap;
  assign w_rd     = ~r_bank_sel;
  assign in_ready = ~r_swap_pend;
  assign w_wr     = in_valid & in_ready & ~rst & (r_wr_cnt < L_DEPTH);
  assign w_swap   = (r_state == R_IDLE) & cons_ready & (r_swap_pend | step_end);
  assign stk_din  = in_data;
  assign bank_sel = r_bank_sel;
  assign overflow = r_overflow;
  stack_pingpong_ctrl_bank_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .i_sel   (w_rd),
    .i_dout0 (stk_dout0),
    .i_dout1 (stk_dout1),
    .i_done  (stk_done),
    .i_empty (stk_empty),
    .o_dout  (w_dout),
    .o_done  (w_done),
    .o_empty (w_empty)
  );
  // read FSM next state and all per-bank strobes / stream outputs
  always_comb begin
    w_state_nxt    = (r_state == R_IDLE)   ? (w_swap ? R_START : R_IDLE) :
                     (r_state == R_START)  ? R_STREAM :
                     (r_state == R_STREAM) ? (w_done ? R_CLEAR : R_STREAM) : R_IDLE;
    stk_wr_en      = w_wr ? {r_bank_sel, ~r_bank_sel} : 2'b00;
    stk_stream_out = (r_state == R_START) ? {w_rd, ~w_rd} : 2'b00;
    stk_clear      = (r_state == R_CLEAR) ? {w_rd, ~w_rd} : 2'b00;
    out_valid      = (r_state == R_STREAM) & ~r_empty_lat;
    out_last       = (r_state == R_STREAM) & ~r_empty_lat & w_done;
    out_data       = w_dout;
    step_done      = r_state == R_CLEAR;
  end
  // read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else r_state <= w_state_nxt;
  end
  // bank swap, pending step, write count, sticky overflow and empty-at-start latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_sel  <= 1'b0;
      r_swap_pend <= 1'b0;
      r_wr_cnt    <= '0;
      r_overflow  <= 1'b0;
      r_empty_lat <= 1'b0;
    end else begin
      r_bank_sel  <= r_bank_sel ^ w_swap;
      r_swap_pend <= ~w_swap & (r_swap_pend | (step_end & in_ready));
      r_wr_cnt    <= w_swap ? '0 : r_wr_cnt + (CW + 1)'(w_wr);
      r_overflow  <= r_overflow | (in_valid & in_ready & ~w_wr);
      r_empty_lat <= (r_state == R_START) ? w_empty : r_empty_lat;
    end
  end
endmodule

// File: tb/tb_stack_pingpong_ctrl.sv
// tb_stack_pingpong_ctrl: directed table, corner sequences and random traffic against a step-level model
module tb_stack_pingpong_ctrl;
  localparam int DW = 4;
  localparam int DEPTH = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic step_end = 1'b0;
  logic cons_ready = 1'b1;
  logic in_ready, out_valid, out_last, step_done, bank_sel, overflow;
  logic [DW-1:0] out_data, stk_din, stk_dout0, stk_dout1;
  logic [1:0] stk_wr_en, stk_clear, stk_stream_out, stk_done, stk_empty;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  stack_pingpong_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .step_end(step_end), .cons_ready(cons_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .step_done(step_done), .stk_din(stk_din), .stk_wr_en(stk_wr_en),
    .stk_clear(stk_clear), .stk_stream_out(stk_stream_out), .stk_dout0(stk_dout0),
    .stk_dout1(stk_dout1), .stk_done(stk_done), .stk_empty(stk_empty), .bank_sel(bank_sel),
    .overflow(overflow)
  );
  // behavioural spike stacks: FIFO-ordered stream starting the cycle after stream_out
  logic [DW-1:0] smem [2][DEPTH];
  int scnt [2];
  int sidx [2];
  bit sact [2];
  assign stk_done  = {sact[1] && (scnt[1] == 0 || sidx[1] == scnt[1] - 1),
                      sact[0] && (scnt[0] == 0 || sidx[0] == scnt[0] - 1)};
  assign stk_empty = {scnt[1] == 0, scnt[0] == 0};
  assign stk_dout0 = smem[0][sidx[0] % DEPTH];
  assign stk_dout1 = smem[1][sidx[1] % DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        scnt[b] <= 0;
        sidx[b] <= 0;
        sact[b] <= 1'b0;
      end else begin
        if (stk_clear[b]) scnt[b] <= 0;
        else if (stk_wr_en[b] && scnt[b] < DEPTH) begin
          smem[b][scnt[b]] <= stk_din;
          scnt[b] <= scnt[b] + 1;
        end
        if (stk_stream_out[b]) begin
          sact[b] <= 1'b1;
          sidx[b] <= 0;
        end else if (sact[b]) begin
          sidx[b] <= sidx[b] + 1;
          if (stk_done[b]) sact[b] <= 1'b0;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // step-level reference: spikes of a step form a list; a swap streams that list with fixed latency
  int m_bank = 0;
  int m_k = 0;
  int m_n = 0;
  int m_mx = 1;
  bit m_pend = 1'b0;
  bit m_ovf = 1'b0;
  logic [DW-1:0] m_cur[$];
  logic [DW-1:0] m_rd[$];
  initial begin
    bit ev, el, ed, idle, swap;
    logic [1:0] rbit, wbit;
    forever begin
      @(negedge clk);
      ev = m_k >= 2 && m_k <= m_n + 1;
      el = m_n > 0 && m_k == m_n + 1;
      ed = m_k > 0 && m_k == m_mx + 2;
      rbit = (m_bank == 1) ? 2'b01 : 2'b10;
      wbit = (m_bank == 1) ? 2'b10 : 2'b01;
      chk("in_ready", 32'(in_ready), 32'(!m_pend));
      chk("bank_sel", 32'(bank_sel), 32'(m_bank));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_last", 32'(out_last), 32'(el));
      chk("step_done", 32'(step_done), 32'(ed));
      chk("stk_clear", 32'(stk_clear), 32'(ed ? rbit : 2'b00));
      chk("stk_stream_out", 32'(stk_stream_out), 32'((m_k == 1) ? rbit : 2'b00));
      chk("stk_wr_en", 32'(stk_wr_en),
          32'((in_valid && !m_pend && !rst && m_cur.size() < DEPTH) ? wbit : 2'b00));
      if (ev) chk("out_data", 32'(out_data), 32'(m_rd[m_k - 2]));
      if (rst) begin
        m_bank = 0; m_k = 0; m_n = 0; m_mx = 1; m_pend = 0; m_ovf = 0;
        m_cur.delete();
        m_rd.delete();
      end else begin
        if (in_valid && !m_pend) begin
          if (m_cur.size() < DEPTH) m_cur.push_back(in_data);
          else m_ovf = 1;
        end
        idle = m_k == 0 || m_k >= m_mx + 3;
        swap = idle && cons_ready && (m_pend || step_end);
        if (m_k > 0) m_k++;
        if (swap) begin
          m_rd = m_cur;
          m_cur.delete();
          m_bank ^= 1;
          m_pend = 0;
          m_n = m_rd.size();
          m_mx = (m_n > 0) ? m_n : 1;
          m_k = 1;
        end else if (step_end && !m_pend) m_pend = 1;
      end
    end
  end
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic se, input logic cr);
    @(posedge clk);
    #1;
    in_valid = iv;
    in_data = d;
    step_end = se;
    cons_ready = cr;
    #3;
  endtask
  typedef struct packed {
    logic iv; logic [3:0] d; logic se; logic cr;
    logic rdy; logic ov; logic [3:0] od; logic last; logic done; logic bank;
    logic [1:0] clr; logic [1:0] wr; logic [1:0] stm;
  } vec_t;
  vec_t tbl [10];
  initial begin
    int nv, lastd;
    logic [17:0] act_v, exp_v;
    tbl[0] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[1] = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[2] = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[4] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01};
    tbl[5] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[6] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[7] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[8] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};
    tbl[9] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("reset bank_sel", 32'(bank_sel), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset strobes", 32'({stk_wr_en, stk_clear, stk_stream_out, out_valid, out_last, step_done}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].se, tbl[i].cr);
      exp_v = {tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].last, tbl[i].done, tbl[i].bank,
               tbl[i].clr, tbl[i].wr, tbl[i].stm};
      act_v = {in_ready, out_valid, tbl[i].ov ? out_data : 4'h0, out_last, step_done, bank_sel,
               stk_clear, stk_wr_en, stk_stream_out};
      chk($sformatf("table row %0d", i), 32'(act_v), 32'(exp_v));
    end
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("empty step bank", 32'(bank_sel), 32'd0);
    chk("empty step stream_out", 32'(stk_stream_out), 32'd2);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("empty step no valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("empty step done", 32'({step_done, stk_clear}), 32'({1'b1, 2'b10}));
    step(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("overflow set", 32'(overflow), 32'd1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    nv = 0;
    repeat (30) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      if (out_valid) nv++;
    end
    chk("full stream count", 32'(nv), 32'd24);
    chk("overflow sticky", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 10), 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("pend in_ready low", 32'(in_ready), 32'd0);
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("pend held without cons_ready", 32'(in_ready), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("pend swap bank", 32'(bank_sel), 32'd1);
    chk("pend swap in_ready", 32'(in_ready), 32'd1);
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 1'b0, 1'b1);
    step(1'b1, 4'd6, 1'b0, 1'b1);
    step(1'b1, 4'd7, 1'b1, 1'b1);
    lastd = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      if (out_valid && out_last) lastd = int'(out_data);
    end
    chk("coincident spike last", 32'(lastd), 32'd7);
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("mid-stream reset", 32'({out_valid, out_last, step_done, bank_sel, in_ready, overflow,
                                 stk_clear, stk_stream_out}), 32'({6'b000010, 4'b0000}));
    rst = 1'b0;
    step(1'b1, 4'd3, 1'b0, 1'b1);
    step(1'b1, 4'd4, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      step(($urandom_range(0, 2) != 0), 4'($urandom), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    repeat (40) step(1'b0, 4'd0, 1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
